// File: rtl/cwm_rd_sched.sv
// Credit-gated read scheduler for the coefficient/weight memory (CWM).
// Walks a block of rows n_rep times, issuing at most one read per cycle
// and only while the downstream weight buffer has a free slot. After the
// last read it waits out the memory latency before pulsing done.
module cwm_rd_sched #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 3,
    parameter int CREDITS = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   n_rows,
    input  logic [15:0]   n_rep,
    input  logic          credit_ret,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LD = DW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] credits, cred_nx;
    logic          ovf;
    logic [DW-1:0] dcnt, dcnt_nx;

    logic [AW-1:0] lat_base;
    logic [AW:0]   lat_rows;
    logic [15:0]   lat_rep;
    logic          latch_cfg;

    logic [AW:0]   row_cnt, row_nx;
    logic [15:0]   rep_cnt, rep_nx;
    logic [AW-1:0] nxt_addr, addr_nx;
    logic [AW-1:0] rd_addr_nx;
    logic          issue_nx, no_issue;
    logic          pass_end, rep_end;

    // Address increment that wraps DEPTH-1 back to 0 for any DEPTH.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        addr_inc = (a == ADDR_TOP) ? '0 : a + 1'b1;
    endfunction

    // Saturating credit update; MSB of the result flags an overflow attempt.
    function automatic logic [CW:0] credit_step(input logic [CW-1:0] c,
                                                input logic          take,
                                                input logic          give);
        credit_step = {1'b0, c};
        if (give && !take) begin
            if (c == CRED_MAX)
                credit_step = {1'b1, c};
            else
                credit_step = {1'b0, c + 1'b1};
        end else if (take && !give) begin
            credit_step = {1'b0, c - 1'b1};
        end
    endfunction

    assign pass_end = ((row_cnt + 1'b1) == lat_rows);
    assign rep_end  = ((rep_cnt + 16'd1) == lat_rep);

    // Next-state, credit and read-issue decisions for the coming cycle.
    always_comb begin
        state_nx  = state;
        dcnt_nx   = dcnt;
        row_nx    = row_cnt;
        rep_nx    = rep_cnt;
        addr_nx   = nxt_addr;
        latch_cfg = 1'b0;
        no_issue  = 1'b0;
        {ovf, cred_nx} = credit_step(credits, rd_en, credit_ret);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = RUN;
                    latch_cfg = 1'b1;
                    row_nx    = '0;
                    rep_nx    = '0;
                    addr_nx   = base_addr;
                    // An empty schedule spends one read-free cycle in RUN
                    no_issue  = (n_rows == '0) || (n_rep == '0);
                end
            end
            RUN: begin
                if ((lat_rows == '0) || (lat_rep == '0)) begin
                    state_nx = FIN;
                end else if (rd_en) begin
                    if (pass_end) begin
                        row_nx  = '0;
                        rep_nx  = rep_cnt + 16'd1;
                        addr_nx = lat_base;
                        if (rep_end) begin
                            state_nx = DRAIN;
                            dcnt_nx  = DRAIN_LD;
                        end
                    end else begin
                        row_nx  = row_cnt + 1'b1;
                        addr_nx = addr_inc(nxt_addr);
                    end
                end
            end
            DRAIN: begin
                if (dcnt == '0)
                    state_nx = FIN;
                else
                    dcnt_nx = dcnt - 1'b1;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        issue_nx   = (state_nx == RUN) && (cred_nx != '0) && !no_issue;
        rd_addr_nx = issue_nx ? addr_nx : rd_addr;
    end

    // Control registers: FSM, registered strobes, credits, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            credits <= CRED_MAX;
            dcnt    <= '0;
        end else begin
            state   <= state_nx;
            rd_en   <= issue_nx;
            rd_addr <= rd_addr_nx;
            busy    <= (state_nx == RUN) || (state_nx == DRAIN);
            done    <= (state_nx == FIN);
            err     <= err | ovf;
            credits <= cred_nx;
            dcnt    <= dcnt_nx;
        end
    end

    // Schedule configuration and walk position; reloaded on every start.
    always_ff @(posedge clk) begin
        if (latch_cfg) begin
            lat_base <= base_addr;
            lat_rows <= n_rows;
            lat_rep  <= n_rep;
        end
        row_cnt  <= row_nx;
        rep_cnt  <= rep_nx;
        nxt_addr <= addr_nx;
    end

endmodule
